// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline (stall/flush/bubble/forward).
// Optional define PIPE_CTRL_FORWARD_EN enables EM/MW forwarding and restricts stalls to load-use.
module pipe_ctrl #(
  parameter int unsigned MC_MAX_CYCLES = 64,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fd_valid,
  input  logic [4:0]       fd_rs1,
  input  logic [4:0]       fd_rs2,
  input  logic             fd_reads_rs1,
  input  logic             fd_reads_rs2,
  input  logic             de_valid,
  input  logic [4:0]       de_rs1,
  input  logic [4:0]       de_rs2,
  input  logic [4:0]       de_rd,
  input  logic             de_is_load,
  input  logic             de_is_multi,
  input  logic             de_is_ebreak,
  input  logic             e_jump,
  input  logic [4:0]       em_rd,
  input  logic             em_is_load,
  input  logic [4:0]       mw_rd,
  input  logic             mc_done,
  output logic             f_stall,
  output logic             d_stall,
  output logic             d_flush,
  output logic             e_flush,
  output logic             e_hold,
  output logic             m_bubble,
  output logic             mc_start,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic             halted,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned WAIT_W = (MC_MAX_CYCLES > 2) ? $clog2(MC_MAX_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MC_MAX_CYCLES - 1);

  typedef enum logic [1:0] {RUN, MULTI, HALT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              halted_q;
  logic              timeout_q;
  logic              timeout_set;
  logic [CNT_W-1:0]  cnt_q;
  logic              data_haz;
  logic [1:0]        sel1;
  logic [1:0]        sel2;

  // A real FD source that is read, nonzero and equal to a producing stage's rd
  function automatic logic src_match(input logic rd_en, input logic [4:0] rs,
                                     input logic [4:0] rd);
    return fd_valid && rd_en && (rs != 5'd0) && (rs == rd);
  endfunction

  logic hit_de;
  logic hit_em;
  assign hit_de = src_match(fd_reads_rs1, fd_rs1, de_rd) | src_match(fd_reads_rs2, fd_rs2, de_rd);
  assign hit_em = src_match(fd_reads_rs1, fd_rs1, em_rd) | src_match(fd_reads_rs2, fd_rs2, em_rd);

`ifdef PIPE_CTRL_FORWARD_EN
  // EM result is forwardable unless it is a load still in flight; EM beats MW
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (rs == 5'd0)                       return 2'b00;
    else if ((rs == em_rd) && !em_is_load) return 2'b01;
    else if (rs == mw_rd)                 return 2'b10;
    else                                  return 2'b00;
  endfunction

  assign data_haz = (hit_de & de_is_load) | (hit_em & em_is_load);
  assign sel1     = fwd_sel(de_rs1);
  assign sel2     = fwd_sel(de_rs2);
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{de_rs1, de_rs2, de_is_load, em_is_load, mw_rd};
  assign data_haz = hit_de | hit_em;
  assign sel1     = 2'b00;
  assign sel2     = 2'b00;
`endif

  // Hazard controls and next-state decode
  always_comb begin
    f_stall      = 1'b0;
    d_stall      = 1'b0;
    d_flush      = 1'b0;
    e_flush      = 1'b0;
    e_hold       = 1'b0;
    m_bubble     = 1'b0;
    mc_start     = 1'b0;
    fwd_rs1_sel  = 2'b00;
    fwd_rs2_sel  = 2'b00;
    state_nxt    = state;
    wait_nxt     = wait_cnt;
    timeout_set  = 1'b0;
    halted       = halted_q & ~reset;
    mc_timeout   = timeout_q & ~reset;
    stall_cycles = reset ? '0 : cnt_q;
    if (reset) begin
      d_flush = 1'b1;
      e_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          fwd_rs1_sel = sel1;
          fwd_rs2_sel = sel2;
          if (de_valid && de_is_ebreak) begin
            f_stall   = 1'b1;
            d_stall   = 1'b1;
            e_flush   = 1'b1;
            state_nxt = HALT;
          end else if (e_jump) begin
            d_flush = 1'b1;
            e_flush = 1'b1;
          end else if (de_valid && de_is_multi) begin
            f_stall   = 1'b1;
            d_stall   = 1'b1;
            e_hold    = 1'b1;
            m_bubble  = 1'b1;
            mc_start  = 1'b1;
            wait_nxt  = '0;
            state_nxt = MULTI;
          end else if (data_haz) begin
            f_stall = 1'b1;
            d_stall = 1'b1;
            e_flush = 1'b1;
          end
        end
        MULTI: begin
          fwd_rs1_sel = sel1;
          fwd_rs2_sel = sel2;
          // mc_done releases DE even on the cycle the timeout would fire
          if (mc_done) begin
            state_nxt = RUN;
          end else begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_hold   = 1'b1;
            m_bubble = 1'b1;
            if (wait_cnt == WAIT_LAST) begin
              timeout_set = 1'b1;
              state_nxt   = HALT;
            end else begin
              wait_nxt = wait_cnt + WAIT_W'(1);
            end
          end
        end
        HALT: begin
          f_stall = 1'b1;
          d_stall = 1'b1;
          e_flush = 1'b1;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // State, wait counter, sticky flags and stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state_nxt == HALT) halted_q <= 1'b1;
      if (timeout_set) timeout_q <= 1'b1;
      if (f_stall && (state != HALT)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed stimulus pushes expected controls, a negedge monitor compares.
module tb_pipe_ctrl;

  localparam int unsigned CNT_W = 32;
`ifdef PIPE_CTRL_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Control vector: {f_stall,d_stall,d_flush,e_flush,e_hold,m_bubble,mc_start,fwd1[1:0],fwd2[1:0],halted,mc_timeout}
  localparam logic [12:0] NONE  = 13'h0000;
  localparam logic [12:0] RSTV  = 13'h0600;
  localparam logic [12:0] JMP   = 13'h0600;
  localparam logic [12:0] STALL = 13'h1A00;
  localparam logic [12:0] ISSUE = 13'h19C0;
  localparam logic [12:0] MWAIT = 13'h1980;
  localparam logic [12:0] HALTV = 13'h1A02;
  localparam logic [12:0] HALTT = 13'h1A03;
  localparam logic [12:0] F1_WB = 13'h0020;
  localparam logic [12:0] F2_EM = 13'h0004;

  logic clk = 1'b0;
  logic reset;
  logic fd_valid, fd_reads_rs1, fd_reads_rs2;
  logic [4:0] fd_rs1, fd_rs2, de_rs1, de_rs2, de_rd, em_rd, mw_rd;
  logic de_valid, de_is_load, de_is_multi, de_is_ebreak, e_jump, em_is_load, mc_done;
  logic f_stall, d_stall, d_flush, e_flush, e_hold, m_bubble, mc_start, halted, mc_timeout;
  logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
  logic [CNT_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_ctrl #(.MC_MAX_CYCLES(64), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .fd_valid(fd_valid), .fd_rs1(fd_rs1), .fd_rs2(fd_rs2),
    .fd_reads_rs1(fd_reads_rs1), .fd_reads_rs2(fd_reads_rs2),
    .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rd(de_rd),
    .de_is_load(de_is_load), .de_is_multi(de_is_multi), .de_is_ebreak(de_is_ebreak),
    .e_jump(e_jump), .em_rd(em_rd), .em_is_load(em_is_load), .mw_rd(mw_rd),
    .mc_done(mc_done),
    .f_stall(f_stall), .d_stall(d_stall), .d_flush(d_flush), .e_flush(e_flush),
    .e_hold(e_hold), .m_bubble(m_bubble), .mc_start(mc_start),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .halted(halted), .mc_timeout(mc_timeout), .stall_cycles(stall_cycles)
  );

  typedef struct {
    string            nm;
    logic [12:0]      ctl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  exp_t             e;
  logic [12:0]      act;
  int               n_chk  = 0;
  int               n_pass = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  // Monitor: every cycle with a queued expectation is compared mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {f_stall, d_stall, d_flush, e_flush, e_hold, m_bubble, mc_start,
             fwd_rs1_sel, fwd_rs2_sel, halted, mc_timeout};
      n_chk++;
      if (act === e.ctl) n_pass++;
      else $display("FAIL %s ctl: got %013b want %013b", e.nm, act, e.ctl);
      n_chk++;
      if (stall_cycles === e.cnt) n_pass++;
      else $display("FAIL %s stall_cycles: got %0d want %0d", e.nm, stall_cycles, e.cnt);
    end
  end

  task automatic clr();
    fd_valid = 0; fd_rs1 = 0; fd_rs2 = 0; fd_reads_rs1 = 0; fd_reads_rs2 = 0;
    de_valid = 0; de_rs1 = 0; de_rs2 = 0; de_rd = 0;
    de_is_load = 0; de_is_multi = 0; de_is_ebreak = 0;
    e_jump = 0; em_rd = 0; em_is_load = 0; mw_rd = 0; mc_done = 0;
  endtask

  task automatic rand_inputs();
    fd_valid = 1'($urandom); fd_rs1 = 5'($urandom); fd_rs2 = 5'($urandom);
    fd_reads_rs1 = 1'($urandom); fd_reads_rs2 = 1'($urandom);
    de_valid = 1'($urandom); de_rs1 = 5'($urandom); de_rs2 = 5'($urandom);
    de_rd = 5'($urandom); de_is_load = 1'($urandom); de_is_multi = 1'($urandom);
    de_is_ebreak = 1'($urandom); e_jump = 1'($urandom); em_rd = 5'($urandom);
    em_is_load = 1'($urandom); mw_rd = 5'($urandom); mc_done = 1'($urandom);
  endtask

  // Queue the expectation for the current cycle, advance the counter model, then step one clock
  task automatic step(input string nm, input logic [12:0] ctl);
    exp_t r;
    r.nm  = nm;
    r.ctl = ctl;
    r.cnt = reset ? '0 : exp_cnt;
    sb.push_back(r);
    if (reset) exp_cnt = '0;
    else if (ctl[12] && !ctl[1]) exp_cnt = exp_cnt + CNT_W'(1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) step("reset", RSTV);
    reset = 1'b0;
    step("idle", NONE);

    fd_valid = 1; fd_rs1 = 5; fd_reads_rs1 = 1; de_rd = 5;
    step("haz_de", STALL);
    de_rd = 0; em_rd = 5;
    step("haz_em", STALL);
    em_rd = 0;
    step("haz_clear", NONE);
    fd_reads_rs1 = 0; de_rd = 5;
    step("no_read", NONE);
    fd_reads_rs1 = 1; fd_valid = 0;
    step("fd_invalid", NONE);
    fd_valid = 1; fd_rs1 = 0; de_rd = 0;
    step("rs_zero", NONE);
    fd_rs2 = 6; fd_reads_rs2 = 1; em_rd = 6;
    step("haz_rs2", STALL);

    clr(); fd_valid = 1; fd_rs1 = 5; fd_reads_rs1 = 1; de_rd = 5; e_jump = 1;
    step("jump_over_haz", JMP);

    clr(); de_valid = 1; de_is_multi = 1;
    step("mc_issue", ISSUE);
    repeat (4) step("mc_wait", MWAIT);
    mc_done = 1; de_valid = 0; de_is_multi = 0;
    step("mc_done", NONE);
    mc_done = 0;
    step("mc_after", NONE);

    de_valid = 1; de_is_multi = 1;
    step("late_issue", ISSUE);
    repeat (63) step("late_wait", MWAIT);
    mc_done = 1; de_valid = 0; de_is_multi = 0;
    step("done_at_limit", NONE);
    mc_done = 0;
    step("no_timeout", NONE);

    de_valid = 1; de_is_multi = 1;
    step("to_issue", ISSUE);
    repeat (64) step("to_wait", MWAIT);
    clr(); e_jump = 1;
    repeat (3) step("to_halt", HALTT);

    reset = 1'b1;
    step("reset2", RSTV);
    reset = 1'b0; clr();
    step("post_reset2", NONE);

    de_valid = 1; de_is_ebreak = 1; e_jump = 1;
    step("ebreak", STALL);
    repeat (100) begin
      rand_inputs();
      step("halt_rand", HALTV);
    end
    clr(); reset = 1'b1;
    step("reset3", RSTV);
    reset = 1'b0;
    step("post_reset3", NONE);

    fd_valid = 1; fd_rs1 = 9; fd_reads_rs1 = 1; em_rd = 9; em_is_load = 1;
    step("load_use_em", STALL);
    em_is_load = 0;
    step("alu_em", FWD ? NONE : STALL);
    em_rd = 0; de_rd = 9; de_is_load = 1;
    step("load_use_de", STALL);
    de_is_load = 0;
    step("alu_de", FWD ? NONE : STALL);

    clr(); em_rd = 3; de_rs2 = 3;
    step("fwd_em", FWD ? F2_EM : NONE);
    mw_rd = 3;
    step("fwd_em_over_mw", FWD ? F2_EM : NONE);
    clr(); mw_rd = 7; de_rs1 = 7;
    step("fwd_mw", FWD ? F1_WB : NONE);
    clr(); em_is_load = 1; em_rd = 3; mw_rd = 3; de_rs1 = 3;
    step("fwd_skip_load", FWD ? F1_WB : NONE);
    clr();
    step("fwd_rs_zero", NONE);

    repeat (2) @(posedge clk);
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
